// File: rtl/serial_mem_if.sv
// Bit-serial memory link between the CPU control FSM (master) and the memory responder (slave).
interface serial_mem_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       sin;
    logic       sin_valid;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd, sin, sin_valid, sout_ready,
        input  cmd_ready, sout, sout_valid, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd, sin, sin_valid, sout_ready,
        output cmd_ready, sout, sout_valid, busy, done, err
    );
endinterface

// File: rtl/serial_mem_responder.sv
// Memory-side responder for the bit-serial CPU memory link: FETCH/LOAD shift a word out, STORE writes RAM.
// Optional even-parity data frames (17 bits) are enabled by defining SERIAL_MEM_PARITY_EN.
module serial_mem_responder #(
    parameter int ADDR_W = 8
) (
    input logic         clk,
    input logic         rst,
    serial_mem_if.slave bus
);

`ifdef SERIAL_MEM_PARITY_EN
    localparam int DW = 17;
`else
    localparam int DW = 16;
`endif

    localparam logic [4:0] LAST_ADDR_BIT = 5'd15;
    localparam logic [4:0] LAST_DATA_BIT = 5'(DW - 1);
    localparam logic [1:0] CMD_STORE     = 2'b10;
    localparam logic [1:0] CMD_RSVD      = 2'b11;

    typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, READ, TX} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-2:0]     data_q, data_d;
    logic [DW-1:0]     tx_q, tx_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [15:0]       mem [2**ADDR_W];
    logic              mem_we;
    logic [DW-1:0]     rx_word;
    logic [15:0]       wr_word;
    logic [DW-1:0]     rd_word;
    logic              parity_ok;

    // Only the index bits are kept: upper address bits shift straight out, giving modulo aliasing.
    assign rx_word = {data_q, bus.sin};

`ifdef SERIAL_MEM_PARITY_EN
    assign wr_word   = rx_word[16:1];
    assign parity_ok = ~^rx_word;
    assign rd_word   = {mem[addr_q], ^mem[addr_q]};
`else
    assign wr_word   = rx_word;
    assign parity_ok = 1'b1;
    assign rd_word   = mem[addr_q];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= 2'b00;
            cnt_q   <= 5'd0;
            addr_q  <= '0;
            data_q  <= '0;
            tx_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // RAM has no reset; the write enable is derived from state, so reset can never commit a write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wr_word;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd == CMD_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        cmd_d   = bus.cmd;
                        cnt_d   = 5'd0;
                        state_d = RX_ADDR;
                    end
                end
            end
            RX_ADDR: begin
                if (bus.sin_valid) begin
                    addr_d = {addr_q[ADDR_W-2:0], bus.sin};
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == LAST_ADDR_BIT) begin
                        cnt_d   = 5'd0;
                        state_d = (cmd_q == CMD_STORE) ? RX_DATA : READ;
                    end
                end
            end
            RX_DATA: begin
                if (bus.sin_valid) begin
                    data_d = rx_word[DW-2:0];
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == LAST_DATA_BIT) begin
                        mem_we  = parity_ok;
                        done_d  = parity_ok;
                        err_d   = ~parity_ok;
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                tx_d    = rd_word;
                cnt_d   = 5'd0;
                state_d = TX;
            end
            TX: begin
                if (bus.sout_ready) begin
                    tx_d  = {tx_q[DW-2:0], 1'b0};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_DATA_BIT) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready  = (state_q == IDLE);
        bus.busy       = (state_q != IDLE);
        bus.sout_valid = (state_q == TX);
        bus.sout       = tx_q[DW-1];
        bus.done       = done_q;
        bus.err        = err_q;
    end

endmodule

// File: tb/tb_serial_mem_responder.sv
// Self-checking bench for serial_mem_responder: directed transactions push expected completions into a
// scoreboard that a negedge monitor pops on every done/err pulse.
module tb_serial_mem_responder;

`ifdef SERIAL_MEM_PARITY_EN
    localparam int DW = 17;
`else
    localparam int DW = 16;
`endif

    localparam logic [1:0] FETCH = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] STORE = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;
    localparam int K_READ  = 0;
    localparam int K_STORE = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int          kind;
        logic [16:0] word;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_mem_if bus();

    serial_mem_responder #(.ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [16:0] expWord(input logic [15:0] d);
`ifdef SERIAL_MEM_PARITY_EN
        return {d, ^d};
`else
        return {1'b0, d};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [1:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
    endtask

    // Gap cycles drive the inverted bit with sin_valid low, so a responder that ignores sin_valid fails.
    task automatic sendBits(input logic [16:0] w, input int n, input bit gaps, input bit noise);
        for (int i = n - 1; i >= 0; i--) begin
            bus.cmd_valid = noise;
            bus.cmd       = RSVD;
            if (gaps && (i % 3 == 0)) begin
                bus.sin_valid = 1'b0;
                bus.sin       = ~w[i];
                tick();
            end
            bus.sin       = w[i];
            bus.sin_valid = 1'b1;
            tick();
        end
        bus.sin_valid = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
    endtask

    task automatic waitIdle(input bit toggle);
        int n = 0;
        while (bus.busy && n < 200) begin
            if (toggle) bus.sout_ready = ~bus.sout_ready;
            tick();
            n++;
        end
        checkOutput("idle_timeout", {31'b0, bus.busy}, 32'd0);
        bus.sout_ready = 1'b1;
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [15:0] addr, input logic [15:0] data,
                                 input bit toggle, input bit gaps, input bit noise, input bit bad_par);
        logic [16:0] wr;
        if (c == RSVD) begin
            sb.push_back('{K_ERR, 17'h0});
            sendCmd(c);
            checkOutput("rsvd_busy", {31'b0, bus.busy}, 32'd0);
            checkOutput("rsvd_ready", {31'b0, bus.cmd_ready}, 32'd1);
            tick();
            return;
        end
        wr = expWord(data);
        if (c == STORE) begin
            if (bad_par) wr[0] = ~wr[0];
            sb.push_back('{bad_par ? K_ERR : K_STORE, 17'h0});
        end else begin
            sb.push_back('{K_READ, wr});
        end
        sendCmd(c);
        checkOutput("accept_busy", {31'b0, bus.busy}, 32'd1);
        checkOutput("accept_ready", {31'b0, bus.cmd_ready}, 32'd0);
        sendBits({1'b0, addr}, 16, gaps, noise);
        if (c == STORE) begin
            sendBits(wr, DW, gaps, 1'b0);
            checkOutput("store_end", {30'b0, bus.done, bus.err}, bad_par ? 32'd1 : 32'd2);
            checkOutput("store_ready", {31'b0, bus.cmd_ready}, 32'd1);
        end else begin
            checkOutput("read_cycle_valid", {31'b0, bus.sout_valid}, 32'd0);
            waitIdle(toggle);
        end
    endtask

    logic [16:0] rx_word;
    int          rx_bits;
    bit          prev_done;
    bit          prev_err;

    // Monitor: bits are sampled at negedge, ahead of the posedge that consumes them.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (rst) begin
            rx_word   = '0;
            rx_bits   = 0;
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (bus.done || bus.err) begin
                kind = bus.err ? K_ERR : ((rx_bits > 0) ? K_READ : K_STORE);
                if (sb.size() == 0) begin
                    checkOutput("spurious_pulse", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("pulse_kind", kind, e.kind);
                    if (e.kind == K_READ) begin
                        checkOutput("rx_word", {15'b0, rx_word}, {15'b0, e.word});
                        checkOutput("rx_bits", rx_bits, DW);
                    end
                end
                checkOutput("done_err_excl", {31'b0, bus.done & bus.err}, 32'd0);
                checkOutput("pulse_width", {31'b0, (bus.done & prev_done) | (bus.err & prev_err)}, 32'd0);
                rx_word = '0;
                rx_bits = 0;
            end
            if (bus.sout_valid && bus.sout_ready) begin
                rx_word = {rx_word[15:0], bus.sout};
                rx_bits++;
            end
            prev_done = bus.done;
            prev_err  = bus.err;
        end
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd        = 2'b00;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.sout_ready = 1'b1;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        checkOutput("rst_sout", {31'b0, bus.sout}, 32'd0);
        checkOutput("rst_sout_valid", {31'b0, bus.sout_valid}, 32'd0);
        checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'b0, bus.done}, 32'd0);
        checkOutput("rst_err", {31'b0, bus.err}, 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(STORE, 16'h0012, 16'hBEEF, 0, 0, 0, 0);
        applyStimulus(LOAD,  16'h0012, 16'hBEEF, 0, 0, 0, 0);
        applyStimulus(STORE, 16'h0105, 16'h1234, 0, 0, 0, 0);
        applyStimulus(FETCH, 16'h0005, 16'h1234, 0, 0, 0, 0);
        applyStimulus(FETCH, 16'h0012, 16'hBEEF, 1, 0, 0, 0);
        applyStimulus(RSVD,  16'h0000, 16'h0000, 0, 0, 0, 0);
        applyStimulus(FETCH, 16'h0105, 16'h1234, 0, 1, 1, 0);
        applyStimulus(STORE, 16'h0040, 16'hA5C3, 0, 1, 0, 0);

        // Reset while the fifth bit (bit 11 of 0xA5C3, a 0) is on the wire.
        sendCmd(FETCH);
        sendBits(17'h00040, 16, 1'b0, 1'b0);
        repeat (5) tick();
        checkOutput("mid_tx_valid", {31'b0, bus.sout_valid}, 32'd1);
        checkOutput("mid_tx_sout", {31'b0, bus.sout}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst_tx_valid", {31'b0, bus.sout_valid}, 32'd0);
        checkOutput("rst_tx_ready", {31'b0, bus.cmd_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();

        applyStimulus(FETCH, 16'h0040, 16'hA5C3, 1, 0, 0, 0);
        applyStimulus(STORE, 16'hFFFF, 16'h0000, 0, 0, 0, 0);
        applyStimulus(STORE, 16'h00FF, 16'h8001, 0, 0, 0, 0);
        applyStimulus(FETCH, 16'hFFFF, 16'h8001, 0, 0, 0, 0);
        applyStimulus(LOAD,  16'h0012, 16'hBEEF, 1, 1, 0, 0);

`ifdef SERIAL_MEM_PARITY_EN
        applyStimulus(STORE, 16'h0003, 16'h00F0, 0, 0, 0, 0);
        applyStimulus(STORE, 16'h0003, 16'h0001, 0, 0, 0, 1);
        applyStimulus(FETCH, 16'h0003, 16'h00F0, 0, 0, 0, 0);
        applyStimulus(STORE, 16'h0003, 16'h0001, 0, 0, 0, 0);
        applyStimulus(FETCH, 16'h0003, 16'h0001, 0, 0, 0, 0);
`endif

        repeat (3) tick();
        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
